// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: FSM state encoding and the
// row/column to key-index mapping used for value bits and event keys.
package keypad_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_SETTLE = 2'd0;
    localparam state_t ST_SAMPLE = 2'd1;
    localparam state_t ST_EMIT   = 2'd2;
    localparam state_t ST_NEXT   = 2'd3;

    // Key at row r, column c lives at bit r*cols+c of the bitmap.
    function automatic int key_index(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Press/release event stream between the scanner and its consumer.
interface keypad_scanner_if #(
    parameter int KW = 4
);

    logic          event_valid;
    logic          event_ready;
    logic [KW-1:0] event_key;
    logic          event_pressed;

    modport master (
        output event_valid,
        output event_key,
        output event_pressed,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_key,
        input  event_pressed,
        output event_ready
    );

endinterface

// File: rtl/keypad_scanner_debounce.sv
// Per-key debounce counter. Counts consecutive samples that disagree with the
// published state and raises flip on the sample that reaches the threshold.
module keypad_debounce #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic raw,
    input  logic state,
    output logic flip
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] THRESHOLD = CW'(DEBOUNCE_SCANS);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          disagree;
    logic          hit;

    assign cnt_inc  = cnt + CW'(1);
    assign disagree = raw ^ state;
    assign hit      = (cnt_inc == THRESHOLD);
    assign flip     = sample_en & disagree & hit;

    // Restart the count on agreement or once a flip has been requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (sample_en) begin
            if (!disagree || hit) begin
                cnt <= '0;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning matrix keypad controller with per-key debounce, a debounced
// key bitmap and a backpressured press/release event stream.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [COLS-1:0]        column,
    input  logic [ROWS-1:0]        row,
    output logic [ROWS*COLS-1:0]   value,
    output logic                   any_pressed,
    keypad_scanner_if.master       evt
);

    localparam int KEYS = ROWS * COLS;
    localparam int KW   = $clog2(KEYS);
    localparam int CLW  = $clog2(COLS);
    localparam int RW   = $clog2(ROWS);
    localparam int SW   = $clog2(SETTLE_CYCLES + 1);

    localparam logic [CLW-1:0] COL_LAST    = CLW'(COLS - 1);
    localparam logic [RW-1:0]  ROW_LAST    = RW'(ROWS - 1);
    localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_t          state;
    logic [CLW-1:0]  col;
    logic [SW-1:0]   settle_cnt;
    logic [RW-1:0]   r_idx;
    logic [ROWS-1:0] pend;
    logic [KEYS-1:0] flip;
    logic [ROWS-1:0] row_flip;
    logic [KW-1:0]   emit_key;
    logic            sampling;
    logic            slot_free;
    logic            emit_load;
    logic            emit_stall;

    assign sampling   = (state == ST_SAMPLE);
    assign emit_key   = KW'(key_index(int'(r_idx), int'(col), COLS));
    assign slot_free  = !evt.event_valid || evt.event_ready;
    assign emit_load  = (state == ST_EMIT) && pend[r_idx] && slot_free;
    assign emit_stall = (state == ST_EMIT) && pend[r_idx] && !slot_free;
    assign any_pressed = |value;

    // One debounce counter per key; only the driven column is sampled.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            localparam int K = gr * COLS + gc;
            keypad_debounce #(
                .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
            ) u_debounce (
                .clk       (clk),
                .rst       (rst),
                .sample_en (sampling && (col == CLW'(gc))),
                .raw       (~row[gr]),
                .state     (value[K]),
                .flip      (flip[K])
            );
        end
        assign row_flip[gr] = |flip[gr*COLS +: COLS];
    end

    // Drive the current column only while settling and sampling.
    always_comb begin
        column = '0;
        if (state == ST_SETTLE || state == ST_SAMPLE) begin
            column = COLS'(1) << col;
        end
    end

    // Scan sequencer: settle, sample, walk the rows for events, next column.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_NEXT;
            col        <= COL_LAST;
            settle_cnt <= '0;
            r_idx      <= '0;
        end else begin
            case (state)
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                ST_SAMPLE: begin
                    r_idx <= '0;
                    state <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (!emit_stall) begin
                        if (r_idx == ROW_LAST) begin
                            r_idx <= '0;
                            state <= ST_NEXT;
                        end else begin
                            r_idx <= r_idx + RW'(1);
                        end
                    end
                end
                ST_NEXT: begin
                    col        <= (col == COL_LAST) ? '0 : col + CLW'(1);
                    settle_cnt <= '0;
                    state      <= ST_SETTLE;
                end
                default: state <= ST_NEXT;
            endcase
        end
    end

    // Rows whose key in this column crossed the debounce threshold.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else if (sampling) begin
            pend <= row_flip;
        end else if (emit_load) begin
            pend[r_idx] <= 1'b0;
        end
    end

    // Event slot and bitmap update together so they never disagree.
    always_ff @(posedge clk) begin
        if (rst) begin
            value             <= '0;
            evt.event_valid   <= 1'b0;
            evt.event_key     <= '0;
            evt.event_pressed <= 1'b0;
        end else if (emit_load) begin
            evt.event_valid   <= 1'b1;
            evt.event_key     <= emit_key;
            evt.event_pressed <= ~value[emit_key];
            value[emit_key]   <= ~value[emit_key];
        end else if (evt.event_valid && evt.event_ready) begin
            evt.event_valid   <= 1'b0;
        end
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner for the CHIP-8 core's hexadecimal keypad and any larger or smaller key matrix. It drives one column at a time and waits a programmable settle time before sampling the active-low rows. It debounces every key over several scans and publishes both a debounced key bitmap and a stream of press/release events over a valid/ready handshake. It sits between the board keypad pins and the CPU's key-wait/skip-if-key logic.

## Interface
- ROWS, default 4: number of row inputs, ≥2.
- COLS, default 4: number of column outputs, ≥2.
- SETTLE_CYCLES, default 16: cycles a column is driven before rows are sampled, ≥1.
- DEBOUNCE_SCANS, default 4: consecutive disagreeing samples required to change a key's state, ≥1.
- KEYS = ROWS*COLS and KW = $clog2(KEYS) are derived; they are not overridable.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- column  out  COLS  one-hot active-high column drive, all-zero when not sampling.
- row  in  ROWS  row sense, active-low (0 = key closed).
- value  out  KEYS  debounced key state, bit r*COLS+c = key at row r, column c.
- any_pressed  out  1  |value.
- event_valid  out  1  event pending.
- event_ready  in  1  consumer accepts the event.
- event_key  out  KW  key index r*COLS+c.
- event_pressed  out  1  1 = press, 0 = release.

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- FSM states: SETTLE, SAMPLE, EMIT, NEXT. Registers: col (0..COLS-1), settle counter, emit row index r, pend[ROWS], per-key debounce counter.
- SETTLE: column = 1<<col. Stay SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: one cycle, column still driven. For each row, raw = ~row[r] is compared with value[k]:
  - If they agree, cnt[k] ← 0.
  - Otherwise cnt[k] ← cnt[k]+1. When the incremented count equals DEBOUNCE_SCANS, pend[r] ← 1 and cnt[k] ← 0.
  - Then go to EMIT with r = 0.
- EMIT: column = 0. Handle one row per cycle:
  - If pend[r] and the event slot is free (slot is free when !event_valid, or event_valid && event_ready this cycle): load event_key = r*COLS+col and event_pressed = ~value[k], toggle value[k], clear pend[r], advance r.
  - If pend[r] and the slot is not free: stall and hold r.
  - If !pend[r]: advance r.
  - After r = ROWS-1 is handled, go to NEXT.
- NEXT: column = 0. col ← (col == COLS-1) ? 0 : col+1. Go to SETTLE. All COLS columns are visited; no column is skipped.
- Event handshake: event_valid stays high with event_key and event_pressed stable until the cycle where event_valid && event_ready. Without a new load it then drops the next cycle. A new event may load in the same cycle the old one is accepted. An event is never dropped; backpressure stalls the scan.
- value and emitted events are always coherent: value[k] changes in the same cycle its event is loaded.

## Timing
- Reset values: state NEXT with col = COLS-1, so column = 0. Also value = 0, any_pressed = 0, event_valid = 0, event_key = 0, event_pressed = 0, all cnt = 0, pend = 0.
- First column (col 0) is driven on the second cycle after rst deasserts.
- Per-column period without stall: SETTLE_CYCLES + 1 + ROWS + 1 cycles. Full scan: COLS × that.
- Press latency: event_valid rises in the EMIT cycle of the DEBOUNCE_SCANS-th consecutive sample of the new level.
- rst mid-operation, including a stalled EMIT or a pending event: all state returns to reset values on that edge. The pending event is discarded.
- Simultaneous changes in one column: events are emitted in ascending row order. Changes in different columns: events follow scan order.

## Structure
- keypad_pkg holds the state enum (SETTLE, SAMPLE, EMIT, NEXT) and a key_index(r, c, cols) function.
- Sub-module keypad_debounce holds one key's counter with inputs sample_en, raw and state, and output flip. It is instantiated KEYS times via generate.

## Test plan
Unless stated, use ROWS=4, COLS=4, SETTLE_CYCLES=2, DEBOUNCE_SCANS=3; per-column period is 8 and full scan is 32.
1. rst high 3 cycles, row=4'hF -> column=0, value=0, event_valid=0. After release, column=0001 for 3 cycles, then 0000 for 5, then 0010, and so on through 1000, then back to 0001.
2. Hold row[1]=0 whenever column[2]=1, with event_ready=1 -> after the 3rd scan one event key=6, pressed=1, value=16'h0040, any_pressed=1. No further events.
3. Key 6 closed for 2 scans, then open -> no event; value stays 0.
4. After step 2, open key 6 for 3 scans -> one event key=6, pressed=0, value=0.
5. event_ready=0 with keys 1 and 5 (col 1, rows 0/1) closed -> event key=1 is held and the FSM stalls in EMIT with column=0 and no column advance. Raise ready for 1 cycle -> key 1 is accepted, key 5 is presented the next cycle, and the scan resumes after it is accepted.
6. rst pulse while event_valid=1 and stalled -> next cycle event_valid=0, value=0, column=0. Separately, with ROWS=2, COLS=3: column cycles 001, 010, 100, and the key at row 1, col 2 reports event_key=5.
